// File: rtl/md_unit_pkg.sv
// Shared constants for the multiply/divide unit.
// The MDCtrl operation codes are also used by the controller.
// The MD_IDLE/MD_RUN FSM state encodings live here too.
package md_unit_pkg;

    // MDCtrl operation codes
    localparam logic [2:0] MD_NONE  = 3'b000;
    localparam logic [2:0] MD_MULT  = 3'b001;
    localparam logic [2:0] MD_MULTU = 3'b010;
    localparam logic [2:0] MD_DIV   = 3'b011;
    localparam logic [2:0] MD_DIVU  = 3'b100;
    localparam logic [2:0] MD_MTHI  = 3'b101;
    localparam logic [2:0] MD_MTLO  = 3'b110;
    localparam logic [2:0] MD_MADD  = 3'b111;

    // FSM state encodings
    localparam logic [0:0] MD_IDLE = 1'b0;
    localparam logic [0:0] MD_RUN  = 1'b1;

endpackage

// File: rtl/md_unit.sv
// md_unit: multi-cycle multiply/divide unit sitting beside the ALU in EX.
// The result is computed when the op is accepted and parked in tmp.
// It is committed to HI/LO once the busy countdown expires.
// Optional feature macro: MD_MADD_EN enables MDCtrl 111 = madd (signed multiply-accumulate).
// When the macro is undefined, code 111 behaves like 000.
module md_unit
    import md_unit_pkg::*;
#(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic [2:0]  MDCtrl,
    input  logic        Start,
    output logic        Busy,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam int CNT_MAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] MULT_N = CNT_W'(MULT_CYCLES);
    localparam logic [CNT_W-1:0] DIV_N  = CNT_W'(DIV_CYCLES);

    logic [0:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [63:0]      tmp_q, tmp_d;
    logic             upd_q, upd_d;
    logic [31:0]      hi_q, hi_d;
    logic [31:0]      lo_q, lo_d;

    // Arithmetic datapath
    logic signed [63:0] mul_s;
    logic [63:0]        mul_u;
    logic [31:0]        b_safe;
    logic [31:0]        a_mag, b_mag, q_mag, r_mag;
    logic [31:0]        quo_s, rem_s, quo_u, rem_u;

    // Operation decode result
    logic [63:0]      op_res;
    logic             op_valid;
    logic             op_upd;
    logic [CNT_W-1:0] op_cycles;

    assign mul_s = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
    assign mul_u = {32'b0, A} * {32'b0, B};

    // Divisor forced to 1 when zero; that result is discarded anyway (op_upd=0).
    assign b_safe = (B == 32'd0) ? 32'd1 : B;

    // Signed divide via magnitudes, so 0x80000000 / -1 naturally yields
    // quotient 0x80000000, remainder 0, and no signed-overflow trap exists.
    assign a_mag = A[31] ? (32'd0 - A) : A;
    assign b_mag = b_safe[31] ? (32'd0 - b_safe) : b_safe;
    assign q_mag = a_mag / b_mag;
    assign r_mag = a_mag % b_mag;
    assign quo_s = (A[31] ^ b_safe[31]) ? (32'd0 - q_mag) : q_mag;
    assign rem_s = A[31] ? (32'd0 - r_mag) : r_mag;
    assign quo_u = A / b_safe;
    assign rem_u = A % b_safe;

    // Decode MDCtrl into the pending result, its latency and whether it commits.
    always_comb begin
        op_res    = 64'd0;
        op_valid  = 1'b0;
        op_upd    = 1'b1;
        op_cycles = MULT_N;
        case (MDCtrl)
            MD_MULT: begin
                op_res   = mul_s;
                op_valid = 1'b1;
            end
            MD_MULTU: begin
                op_res   = mul_u;
                op_valid = 1'b1;
            end
            MD_DIV: begin
                op_res    = {rem_s, quo_s};
                op_valid  = 1'b1;
                op_upd    = (B != 32'd0);
                op_cycles = DIV_N;
            end
            MD_DIVU: begin
                op_res    = {rem_u, quo_u};
                op_valid  = 1'b1;
                op_upd    = (B != 32'd0);
                op_cycles = DIV_N;
            end
`ifdef MD_MADD_EN
            MD_MADD: begin
                // Accumulates onto HI/LO as they stand at the Start edge.
                op_res   = {hi_q, lo_q} + mul_s;
                op_valid = 1'b1;
            end
`endif
            default: begin
                op_valid = 1'b0;
            end
        endcase
    end

    // Next-state logic for the IDLE/RUN FSM, countdown and HI/LO writes.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        tmp_d   = tmp_q;
        upd_d   = upd_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        if (state_q == MD_IDLE) begin
            if (Start && op_valid) begin
                state_d = MD_RUN;
                cnt_d   = op_cycles;
                tmp_d   = op_res;
                upd_d   = op_upd;
            end else if (MDCtrl == MD_MTHI) begin
                hi_d = A;
            end else if (MDCtrl == MD_MTLO) begin
                lo_d = A;
            end
        end else begin
            // Start/mthi/mtlo are ignored while an op is in flight.
            if (cnt_q <= CNT_W'(1)) begin
                state_d = MD_IDLE;
                cnt_d   = '0;
                if (upd_q) begin
                    hi_d = tmp_q[63:32];
                    lo_d = tmp_q[31:0];
                end
            end else begin
                cnt_d = cnt_q - CNT_W'(1);
            end
        end
    end

    // State registers; reset aborts any op immediately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= MD_IDLE;
            cnt_q   <= '0;
            tmp_q   <= 64'd0;
            upd_q   <= 1'b0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            tmp_q   <= tmp_d;
            upd_q   <= upd_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    assign Busy = (state_q == MD_RUN);
    assign HI   = hi_q;
    assign LO   = lo_q;

endmodule
